// File: rtl/insight_tl_txn_tracker.sv
// Passive TileLink A/D transaction tracker: matches A requests to D responses by
// source ID, measures latency, flags anomalies and queues completion records.
module insight_tl_txn_tracker #(
  parameter int SOURCE_BITS     = 4,
  parameter int ADDR_W          = 32,
  parameter int BEAT_BYTES_LOG2 = 3,
  parameter int LAT_W           = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  // snooped A channel
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [2:0]             a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [ADDR_W-1:0]      a_address,
  // snooped D channel
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [2:0]             d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  input  logic                   d_denied,
  input  logic                   d_corrupt,
  // record stream
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [SOURCE_BITS-1:0] rec_source,
  output logic [ADDR_W-1:0]      rec_addr,
  output logic [2:0]             rec_opcode,
  output logic [LAT_W-1:0]       rec_latency,
  output logic                   rec_err,
  // status
  output logic                   err_unexpected_d,
  output logic                   err_dup_a,
  output logic [7:0]             drop_count,
  output logic [SOURCE_BITS:0]   outstanding_count
);

  localparam int N      = 1 << SOURCE_BITS;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int REC_W  = SOURCE_BITS + ADDR_W + 3 + LAT_W + 1;
  localparam logic [2:0] BBL = 3'(BEAT_BYTES_LOG2);

  // a_size does not influence tracking; only the D side defines message length
  logic unused_inputs;
  assign unused_inputs = ^a_size;

  // ---------------------------------------------------------------------------
  // Handshake decode and D message framing
  // ---------------------------------------------------------------------------
  logic a_fire;
  logic d_fire;
  logic [7:0] beats_total;
  logic [7:0] beat_cnt_reg;
  logic       err_acc_reg;
  logic       d_last;
  logic       d_err_msg;

  assign a_fire = a_valid & a_ready;
  assign d_fire = d_valid & d_ready;

  always_comb begin
    beats_total = 8'd1;
    if (d_opcode == 3'd1 && d_size > BBL) begin
      beats_total = 8'd1 << (d_size - BBL);
    end
  end

  assign d_last    = d_fire && (beat_cnt_reg == beats_total - 8'd1);
  assign d_err_msg = err_acc_reg | d_denied | d_corrupt;

  always_ff @(posedge clock) begin
    if (reset) begin
      beat_cnt_reg <= '0;
      err_acc_reg  <= 1'b0;
    end else if (d_fire) begin
      if (d_last) begin
        beat_cnt_reg <= '0;
        err_acc_reg  <= 1'b0;
      end else begin
        beat_cnt_reg <= beat_cnt_reg + 8'd1;
        err_acc_reg  <= d_err_msg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-source tracker entries
  // ---------------------------------------------------------------------------
  logic [N-1:0]      valid_reg;
  logic [N-1:0]      valid_next;
  logic [ADDR_W-1:0] addr_reg   [N];
  logic [2:0]        opcode_reg [N];
  logic [LAT_W-1:0]  age_reg    [N];

  logic             hit;
  logic             unexpected_set;
  logic             dup_set;
  logic [LAT_W-1:0] hit_age;
  logic [LAT_W-1:0] hit_latency;

  assign hit            = d_last & valid_reg[d_source];
  assign unexpected_set = d_last & ~valid_reg[d_source];
  // A same-cycle completion on the same source retires the old entry first
  assign dup_set        = a_fire & valid_reg[a_source] & ~(d_last && (d_source == a_source));
  assign hit_age        = age_reg[d_source];
  assign hit_latency    = (hit_age == '1) ? hit_age : hit_age + LAT_W'(1);

  for (genvar gi = 0; gi < N; gi++) begin : g_valid_next
    assign valid_next[gi] = (a_fire && (a_source == SOURCE_BITS'(gi))) |
                            (valid_reg[gi] & ~(hit && (d_source == SOURCE_BITS'(gi))));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= '0;
      for (int i = 0; i < N; i++) begin
        addr_reg[i]   <= '0;
        opcode_reg[i] <= '0;
        age_reg[i]    <= '0;
      end
    end else begin
      valid_reg <= valid_next;
      for (int i = 0; i < N; i++) begin
        if (a_fire && (a_source == SOURCE_BITS'(i))) begin
          addr_reg[i]   <= a_address;
          opcode_reg[i] <= a_opcode;
          age_reg[i]    <= '0;
        end else if (valid_reg[i] && (age_reg[i] != '1)) begin
          age_reg[i] <= age_reg[i] + LAT_W'(1);
        end
      end
    end
  end

  logic [SOURCE_BITS:0] outstanding_next;
  logic [SOURCE_BITS:0] outstanding_count_reg;

  always_comb begin
    outstanding_next = '0;
    for (int i = 0; i < N; i++) begin
      outstanding_next = outstanding_next + (SOURCE_BITS+1)'(valid_next[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags
  // ---------------------------------------------------------------------------
  logic       err_unexpected_d_reg;
  logic       err_dup_a_reg;
  logic [7:0] drop_count_reg;
  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_unexpected_d_reg  <= 1'b0;
      err_dup_a_reg         <= 1'b0;
      drop_count_reg        <= '0;
      outstanding_count_reg <= '0;
    end else begin
      outstanding_count_reg <= outstanding_next;
      if (unexpected_set) err_unexpected_d_reg <= 1'b1;
      if (dup_set)        err_dup_a_reg        <= 1'b1;
      if (push_req && !push_ok && drop_count_reg != 8'hFF) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Record FIFO (head shown directly from storage, zeroed while empty)
  // ---------------------------------------------------------------------------
  logic [REC_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic [REC_W-1:0] push_data;
  logic [REC_W-1:0] head_data;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign pop        = ~fifo_empty & rec_ready;
  assign push_req   = hit;
  // When full, a same-cycle pop frees the head slot, which is the write slot
  assign push_ok    = push_req & (~fifo_full | pop);
  assign push_data  = {d_source, addr_reg[d_source], opcode_reg[d_source], hit_latency, d_err_msg};
  assign head_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
    end
  end

  assign rec_valid = ~fifo_empty;
  assign {rec_source, rec_addr, rec_opcode, rec_latency, rec_err} = head_data;

  assign err_unexpected_d  = err_unexpected_d_reg;
  assign err_dup_a         = err_dup_a_reg;
  assign drop_count        = drop_count_reg;
  assign outstanding_count = outstanding_count_reg;

endmodule

// File: tb/tb_insight_tl_txn_tracker.sv
// Directed bench for insight_tl_txn_tracker: inputs driven on the falling edge,
// outputs checked on the following falling edge.
module tb_insight_tl_txn_tracker;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_size;
  logic [3:0]  d_source;
  logic        d_denied, d_corrupt;
  logic        rec_valid, rec_ready;
  logic [3:0]  rec_source;
  logic [31:0] rec_addr;
  logic [2:0]  rec_opcode;
  logic [15:0] rec_latency;
  logic        rec_err;
  logic        err_unexpected_d, err_dup_a;
  logic [7:0]  drop_count;
  logic [4:0]  outstanding_count;

  int checks = 0;
  int errors = 0;

  insight_tl_txn_tracker dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_source(rec_source),
    .rec_addr(rec_addr), .rec_opcode(rec_opcode), .rec_latency(rec_latency),
    .rec_err(rec_err), .err_unexpected_d(err_unexpected_d), .err_dup_a(err_dup_a),
    .drop_count(drop_count), .outstanding_count(outstanding_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic [3:0] src, input logic [31:0] addr,
                         input logic [2:0] op, input logic [2:0] size);
    a_valid = 1'b1; a_ready = 1'b1; a_source = src; a_address = addr;
    a_opcode = op; a_size = size;
  endtask

  task automatic drive_d(input logic [3:0] src, input logic [2:0] op,
                         input logic [2:0] size, input logic corrupt);
    d_valid = 1'b1; d_ready = 1'b1; d_source = src; d_opcode = op;
    d_size = size; d_corrupt = corrupt; d_denied = 1'b0;
  endtask

  task automatic idle_bus();
    a_valid = 1'b0; a_ready = 1'b0; d_valid = 1'b0; d_ready = 1'b0;
    d_corrupt = 1'b0; d_denied = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  initial begin
    reset = 1'b1; rec_ready = 1'b0;
    a_opcode = '0; a_size = '0; a_source = '0; a_address = '0;
    d_opcode = '0; d_size = '0; d_source = '0;
    idle_bus();
    tick(); tick();
    check("reset_rec_valid", 32'(rec_valid), 32'd0);
    check("reset_rec_addr", rec_addr, 32'd0);
    check("reset_outstanding", 32'(outstanding_count), 32'd0);
    check("reset_drop", 32'(drop_count), 32'd0);
    check("reset_errs", {30'd0, err_unexpected_d, err_dup_a}, 32'd0);
    reset = 1'b0; tick();

    // valid without ready has no effect
    a_valid = 1'b1; a_ready = 1'b0; a_source = 4'd9; tick(); idle_bus();
    check("nofire_outstanding", 32'(outstanding_count), 32'd0);

    // single-beat Get, latency 5
    drive_a(4'd2, 32'h8000_0040, 3'd4, 3'd3); tick(); idle_bus();
    check("t1_outstanding_1", 32'(outstanding_count), 32'd1);
    check("t1_no_rec", 32'(rec_valid), 32'd0);
    repeat (4) tick();
    drive_d(4'd2, 3'd1, 3'd3, 1'b0); tick(); idle_bus();
    check("t1_rec_valid", 32'(rec_valid), 32'd1);
    check("t1_rec_source", 32'(rec_source), 32'd2);
    check("t1_rec_addr", rec_addr, 32'h8000_0040);
    check("t1_rec_opcode", 32'(rec_opcode), 32'd4);
    check("t1_rec_latency", 32'(rec_latency), 32'd5);
    check("t1_rec_err", 32'(rec_err), 32'd0);
    check("t1_outstanding_0", 32'(outstanding_count), 32'd0);
    tick();
    check("t1_hold_addr", rec_addr, 32'h8000_0040);
    rec_ready = 1'b1; tick(); rec_ready = 1'b0;
    check("t1_popped", 32'(rec_valid), 32'd0);

    // 8-beat Get with corrupt on beat 3
    drive_a(4'd3, 32'h0000_1000, 3'd4, 3'd6); tick(); idle_bus();
    tick(); tick();
    for (int b = 1; b <= 8; b++) begin
      drive_d(4'd3, 3'd1, 3'd6, b == 3); tick(); idle_bus();
      if (b < 8) check($sformatf("t2_no_rec_beat%0d", b), 32'(rec_valid), 32'd0);
    end
    check("t2_rec_valid", 32'(rec_valid), 32'd1);
    check("t2_rec_err", 32'(rec_err), 32'd1);
    check("t2_rec_latency", 32'(rec_latency), 32'd10);
    rec_ready = 1'b1; tick(); rec_ready = 1'b0;
    check("t2_single_record", 32'(rec_valid), 32'd0);

    // unexpected D, then duplicate A
    drive_d(4'd7, 3'd0, 3'd2, 1'b0); tick(); idle_bus();
    check("t3_unexpected", 32'(err_unexpected_d), 32'd1);
    check("t3_no_rec", 32'(rec_valid), 32'd0);
    check("t3_no_dup_yet", 32'(err_dup_a), 32'd0);
    drive_a(4'd1, 32'h0000_0100, 3'd0, 3'd2); tick();
    drive_a(4'd1, 32'h0000_0200, 3'd0, 3'd2); tick(); idle_bus();
    check("t3_dup", 32'(err_dup_a), 32'd1);
    check("t3_outstanding", 32'(outstanding_count), 32'd1);
    drive_d(4'd1, 3'd0, 3'd2, 1'b0); tick(); idle_bus();
    check("t3_rec_addr", rec_addr, 32'h0000_0200);
    check("t3_rec_latency", 32'(rec_latency), 32'd1);
    rec_ready = 1'b1; tick(); rec_ready = 1'b0;

    // FIFO overflow: 7 completions into a depth-4 FIFO
    for (int i = 0; i < 7; i++) begin
      drive_a(4'(i), 32'h1000 + 32'(4 * i), 3'd0, 3'd2); tick(); idle_bus();
      drive_d(4'(i), 3'd0, 3'd2, 1'b0); tick(); idle_bus();
    end
    check("t4_drop_count", 32'(drop_count), 32'd3);
    check("t4_outstanding", 32'(outstanding_count), 32'd0);
    check("t4_first_latency", 32'(rec_latency), 32'd1);
    rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_drain_valid%0d", i), 32'(rec_valid), 32'd1);
      check($sformatf("t4_drain_addr%0d", i), rec_addr, 32'h1000 + 32'(4 * i));
      check($sformatf("t4_drain_src%0d", i), 32'(rec_source), 32'(i));
      tick();
    end
    rec_ready = 1'b0;
    check("t4_drained", 32'(rec_valid), 32'd0);

    // latency saturation and same-cycle completion + reissue
    do_reset();
    check("t5_dup_cleared", 32'(err_dup_a), 32'd0);
    check("t5_drop_cleared", 32'(drop_count), 32'd0);
    drive_a(4'd5, 32'h0000_A000, 3'd4, 3'd3); tick(); idle_bus();
    repeat (65600) tick();
    drive_d(4'd5, 3'd1, 3'd3, 1'b0);
    drive_a(4'd5, 32'h0000_B000, 3'd4, 3'd3); tick(); idle_bus();
    check("t5_rec_valid", 32'(rec_valid), 32'd1);
    check("t5_rec_latency_sat", 32'(rec_latency), 32'h0000_FFFF);
    check("t5_rec_addr_old", rec_addr, 32'h0000_A000);
    check("t5_outstanding", 32'(outstanding_count), 32'd1);
    check("t5_no_dup", 32'(err_dup_a), 32'd0);
    check("t5_no_unexpected", 32'(err_unexpected_d), 32'd0);
    rec_ready = 1'b1; tick(); rec_ready = 1'b0;
    drive_d(4'd5, 3'd1, 3'd3, 1'b0); tick(); idle_bus();
    check("t5_new_addr", rec_addr, 32'h0000_B000);
    check("t5_new_latency", 32'(rec_latency), 32'd2);

    // reset in the middle of an 8-beat message
    do_reset();
    drive_a(4'd4, 32'h0000_C000, 3'd4, 3'd6); tick(); idle_bus();
    for (int b = 1; b <= 3; b++) begin
      drive_d(4'd4, 3'd1, 3'd6, 1'b1); tick(); idle_bus();
    end
    drive_d(4'd4, 3'd1, 3'd6, 1'b0); reset = 1'b1; tick(); idle_bus();
    check("t6_rst_rec_valid", 32'(rec_valid), 32'd0);
    check("t6_rst_outstanding", 32'(outstanding_count), 32'd0);
    check("t6_rst_errs", {30'd0, err_unexpected_d, err_dup_a}, 32'd0);
    check("t6_rst_drop", 32'(drop_count), 32'd0);
    check("t6_rst_latency", 32'(rec_latency), 32'd0);
    reset = 1'b0; tick();
    for (int b = 1; b <= 8; b++) begin
      drive_d(4'd4, 3'd1, 3'd6, 1'b0); tick(); idle_bus();
      if (b < 8) check($sformatf("t6_no_unexp_beat%0d", b), 32'(err_unexpected_d), 32'd0);
    end
    check("t6_unexpected", 32'(err_unexpected_d), 32'd1);
    check("t6_no_rec", 32'(rec_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/insight_tl_txn_tracker.md
# insight_tl_txn_tracker

Passive TileLink A/D-channel transaction tracker for the Insight trace path, parametrised in source-ID width, beat width and record-buffer depth. It snoops one hart's TL port, matches each A request to its D response by source ID, measures request-to-completion latency and flags protocol anomalies. Completed transactions are buffered and emitted as records on a valid/ready stream toward the Insight trace encoder. The block never drives the snooped TL handshake.

## Interface
- SOURCE_BITS, 4, source-ID width; tracker has 2^SOURCE_BITS entries
- ADDR_W, 32, address width
- BEAT_BYTES_LOG2, 3, log2 of D-channel data bytes per beat
- LAT_W, 16, latency counter width
- FIFO_DEPTH, 4, record FIFO depth (power of two, >=2)
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- a_valid, a_ready  in  1  snooped A handshake; A fire = a_valid & a_ready
- a_opcode  in  3  TL A opcode
- a_size  in  3  log2 bytes
- a_source  in  SOURCE_BITS  source ID
- a_address  in  ADDR_W  request address
- d_valid, d_ready  in  1  snooped D handshake; D fire = d_valid & d_ready
- d_opcode  in  3  TL D opcode (AccessAck=0, AccessAckData=1)
- d_size  in  3  log2 bytes
- d_source  in  SOURCE_BITS  source ID
- d_denied, d_corrupt  in  1  D error bits
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_source  out  SOURCE_BITS; rec_addr  out  ADDR_W; rec_opcode  out  3 (A opcode)
- rec_latency  out  LAT_W  cycles from A fire to last D beat fire, saturating
- rec_err  out  1  OR of d_denied|d_corrupt over all beats
- err_unexpected_d  out  1  sticky: D completed with no outstanding entry
- err_dup_a  out  1  sticky: A fired on a source already outstanding
- drop_count  out  8  saturating count of records lost to full FIFO
- outstanding_count  out  SOURCE_BITS+1  valid tracker entries

## Operation
- Entry per source: valid, addr, opcode, age (LAT_W, saturating at all-ones).
- A fire: entry[a_source] <= {1, a_address, a_opcode, age=0}; if already valid, set err_dup_a and overwrite.
- Every cycle each valid entry's age increments by 1, saturating.
- D beats per message: d_opcode==1 and d_size>BEAT_BYTES_LOG2 → 2^(d_size−BEAT_BYTES_LOG2); else 1. One beat counter (D messages do not interleave); resets to 0 on last beat.
- Error accumulator ORs d_denied|d_corrupt over beats of the current message; cleared on last beat.
- Last D beat: if entry[d_source] valid → push record {source, addr, opcode, latency=age+1 saturating, err}, clear entry; else set err_unexpected_d, push nothing.
- Same-cycle A fire and last-D fire on the same source: D resolves against the old entry first, then A installs the new one; no err_dup_a.
- FIFO push accepted if not full or a pop occurs the same cycle; otherwise record dropped and drop_count++ (saturates at 255).
- outstanding_count reflects post-update entry state, registered.

## Timing
- Reset: all entries invalid, beat counter 0, FIFO empty, rec_valid=0, rec_* fields 0, sticky errors 0, drop_count 0, outstanding_count 0.
- Record visible on rec_valid the cycle after the last D beat fires (1-cycle latency); pop on rec_valid & rec_ready; rec_* held stable while rec_valid & !rec_ready.
- Error flags assert the cycle after the triggering fire; clear only on reset.
- Reset asserted mid-message discards the beat counter, accumulator, all entries and FIFO contents; first cycle after reset deasserts is idle.
- Non-firing cycles (valid without ready) have no effect.

## Test plan
- Get (opcode 4) size 3, source 2, addr 0x8000_0040, A fire cycle 10, single AccessAckData fire cycle 15 → rec_valid cycle 16, rec_latency 5, rec_err 0, outstanding 1→0.
- Get size 6 (8 beats), beats fire cycles 20–27 with d_corrupt on beat 3 → exactly one record after beat 8, rec_err 1; no record after beats 1–7.
- D AccessAck on source 7 with no A → err_unexpected_d=1 next cycle, no record; second A on outstanding source 1 → err_dup_a=1, later record carries the second address.
- rec_ready=0, complete FIFO_DEPTH+3 transactions → FIFO holds 4, drop_count=3; then rec_ready=1 → 4 records drain in order, one per cycle.
- Hold D 70000 cycles with LAT_W=16 → rec_latency 0xFFFF; same-cycle last-D and new A on source 5 → record for old, new entry valid, no dup error.
- Reset during beat 4 of 8 → all outputs at reset values; post-reset beats produce err_unexpected_d on completion.
